// File: rtl/counter_pkg.sv
// counter_pkg
//  Shared definitions for the counter/timer blocks.
//  - DIR_UP / DIR_DOWN : encodings of the counter direction input.
//  - clog2(n)          : width needed to hold 0..n-1, never less than 1 bit,
//                        so a divide-by-1 prescaler still has a legal register.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
//  Divides a qualified enable down to one tick per PRESCALE enabled cycles.
//  Ports:
//    clk   in  1  clock, rising edge
//    rst   in  1  synchronous reset, active high
//    clr   in  1  synchronous phase restart (same effect as rst)
//    en    in  1  advance the phase counter this cycle
//    tick  out 1  high in the enabled cycle that completes a full period
//  The phase holds while en is low, so gaps in en stretch the period
//  by exactly the number of idle cycles. PRESCALE=1 makes tick follow en.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_reg;

  assign tick = en && (cnt_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + PW'(1);
    end
  end

endmodule

// File: rtl/updown_counter_n.sv
// updown_counter_n
//  Fully synchronous up/down counter over 0..MAX_VAL with load, enable,
//  prescaler and a registered terminal-count pulse.
//  Ports:
//    clk       in  1      clock, rising edge
//    rst       in  1      synchronous reset, active high
//    en        in  1      count enable (advances prescaler)
//    up        in  1      1 = increment, 0 = decrement
//    load      in  1      synchronous load of load_val (clamped to MAX_VAL)
//    load_val  in  WIDTH  value to load
//    q         out WIDTH  registered count
//    tc        out 1      registered pulse, cycle after a step at the bound
//    zero      out 1      combinational (q == 0)
//  Priority per edge: rst > load > step > hold.
//  Build option: define UDCNT_SATURATE_EN to saturate at the bounds instead
//  of wrapping; tc then flags every step attempted at a bound.
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int RST_VAL  = MAX_VAL,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             tc_reg;
  logic             tc_next;
  logic             tick;
  logic [WIDTH-1:0] load_clamped;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (en),
    .tick (tick)
  );

  assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;

  // Bounds are detected by explicit compare so a MAX_VAL below 2**WIDTH-1
  // wraps at the programmed modulus rather than at the register width.
  always_comb begin
    q_next  = q_reg;
    tc_next = 1'b0;
    if (tick) begin
      if (up == DIR_UP) begin
        if (q_reg == MAX_Q) begin
          tc_next = 1'b1;
`ifdef UDCNT_SATURATE_EN
          q_next  = q_reg;
`else
          q_next  = '0;
`endif
        end else begin
          q_next = q_reg + WIDTH'(1);
        end
      end else begin
        if (q_reg == '0) begin
          tc_next = 1'b1;
`ifdef UDCNT_SATURATE_EN
          q_next  = q_reg;
`else
          q_next  = MAX_Q;
`endif
        end else begin
          q_next = q_reg - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg  <= RST_Q;
      tc_reg <= 1'b0;
    end else if (load) begin
      q_reg  <= load_clamped;
      tc_reg <= 1'b0;
    end else begin
      q_reg  <= q_next;
      tc_reg <= tc_next;
    end
  end

  assign q    = q_reg;
  assign tc   = tc_reg;
  assign zero = (q_reg == '0);

endmodule

// File: tb/tb_updown_counter_n.sv
module tb_updown_counter_n;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [4:0] lv = 5'd0;

  logic [3:0] q0, q2;
  logic [4:0] q1;
  logic       tc0, tc1, tc2, z0, z1, z2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // u0: defaults, u1: 5-bit with modulus 12, u2: divide-by-3 prescaler
  updown_counter_n u0 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(lv[3:0]), .q(q0), .tc(tc0), .zero(z0)
  );
  updown_counter_n #(.WIDTH(5), .MAX_VAL(11), .RST_VAL(11)) u1 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(lv), .q(q1), .tc(tc1), .zero(z1)
  );
  updown_counter_n #(.PRESCALE(3)) u2 (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
    .load_val(lv[3:0]), .q(q2), .tc(tc2), .zero(z2)
  );

  // Reference model: count value and count of enabled cycles, plain integers
  int maxv [3] = '{15, 11, 15};
  int rstv [3] = '{15, 11, 15};
  int pre  [3] = '{1, 1, 3};
  int mask [3] = '{15, 31, 15};
  int mq [3];
  int mp [3];
  bit mtc [3];
  bit mvalid = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int lvm;
      lvm = int'(lv) & mask[i];
      if (rst) begin
        mq[i] = rstv[i]; mp[i] = 0; mtc[i] = 1'b0;
      end else if (load) begin
        mq[i] = (lvm > maxv[i]) ? maxv[i] : lvm; mp[i] = 0; mtc[i] = 1'b0;
      end else if (en) begin
        mtc[i] = 1'b0;
        mp[i] = mp[i] + 1;
        if (mp[i] == pre[i]) begin
          mp[i] = 0;
`ifdef UDCNT_SATURATE_EN
          if (up && mq[i] == maxv[i]) mtc[i] = 1'b1;
          else if (!up && mq[i] == 0) mtc[i] = 1'b1;
          else mq[i] = up ? mq[i] + 1 : mq[i] - 1;
`else
          mtc[i] = up ? (mq[i] == maxv[i]) : (mq[i] == 0);
          mq[i] = up ? (mq[i] + 1) % (maxv[i] + 1) : (mq[i] + maxv[i]) % (maxv[i] + 1);
`endif
        end
      end else begin
        mtc[i] = 1'b0;
      end
    end
    if (rst) mvalid = 1'b1;
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    if (mvalid) begin
      cmp("m_q0", int'(q0), mq[0]);  cmp("m_tc0", int'(tc0), int'(mtc[0]));
      cmp("m_z0", int'(z0), int'(mq[0] == 0));
      cmp("m_q1", int'(q1), mq[1]);  cmp("m_tc1", int'(tc1), int'(mtc[1]));
      cmp("m_z1", int'(z1), int'(mq[1] == 0));
      cmp("m_q2", int'(q2), mq[2]);  cmp("m_tc2", int'(tc2), int'(mtc[2]));
      cmp("m_z2", int'(z2), int'(mq[2] == 0));
    end
  end

  // Apply inputs for one edge; returns 1 time unit after that edge
  task automatic step(input bit r, input bit e, input bit u, input bit l, input int v);
    rst = r; en = e; up = u; load = l; lv = 5'(v);
    @(posedge clk);
    #1;
    $display("txn rst=%0b en=%0b up=%0b load=%0b lv=%0d -> q0=%0d tc0=%0b q1=%0d tc1=%0b q2=%0d tc2=%0b",
             r, e, u, l, v, q0, tc0, q1, tc1, q2, tc2);
  endtask

  initial begin
    @(posedge clk);
    #1;

    // 1: reset state, then 16 down steps through the wrap
    step(1, 0, 0, 0, 0);
    cmp("rst_q0", int'(q0), 15); cmp("rst_tc0", int'(tc0), 0);
    cmp("rst_z0", int'(z0), 0);  cmp("rst_q1", int'(q1), 11);
    cmp("rst_q2", int'(q2), 15);
    for (int k = 1; k <= 16; k++) begin
      step(0, 1, 0, 0, 0);
      cmp("down_q0", int'(q0), (k == 16) ? 15 : 15 - k);
      cmp("down_tc0", int'(tc0), (k == 16) ? 1 : 0);
      cmp("down_z0", int'(z0), (k == 15) ? 1 : 0);
    end

    // 2: load 14 then count up through the wrap
    step(0, 1, 1, 1, 14);
    cmp("ld14_q0", int'(q0), 14); cmp("ld14_q1", int'(q1), 11);
    cmp("ld14_tc0", int'(tc0), 0);
    step(0, 1, 1, 0, 0);
    cmp("up1_q0", int'(q0), 15); cmp("up1_tc0", int'(tc0), 0);
    cmp("up1_q1", int'(q1), 0);  cmp("up1_tc1", int'(tc1), 1);
    step(0, 1, 1, 0, 0);
    cmp("up2_q0", int'(q0), 0);  cmp("up2_tc0", int'(tc0), 1);
    cmp("up2_z0", int'(z0), 1);
    step(0, 1, 1, 0, 0);
    cmp("up3_q0", int'(q0), 1);  cmp("up3_tc0", int'(tc0), 0);

    // 3: clamped load on the modulus-12 counter, load suppresses the step
    step(0, 1, 1, 1, 20);
    cmp("ld20_q1", int'(q1), 11); cmp("ld20_tc1", int'(tc1), 0);
    cmp("ld20_q0", int'(q0), 4);
    step(0, 1, 1, 0, 0);
    cmp("wrap_q1", int'(q1), 0);  cmp("wrap_tc1", int'(tc1), 1);
    step(0, 1, 1, 1, 5);
    cmp("ld5_q1", int'(q1), 5);   cmp("ld5_q0", int'(q0), 5);
    cmp("ld5_tc1", int'(tc1), 0);

    // 4: prescaler period and a 2-cycle en gap
    step(1, 0, 0, 0, 0);
    cmp("ps_rst_q2", int'(q2), 15);
    step(0, 1, 0, 0, 0); cmp("ps1_q2", int'(q2), 15);
    step(0, 1, 0, 0, 0); cmp("ps2_q2", int'(q2), 15);
    step(0, 1, 0, 0, 0); cmp("ps3_q2", int'(q2), 14);
    step(0, 1, 0, 0, 0); cmp("ps4_q2", int'(q2), 14);
    step(0, 0, 0, 0, 0); cmp("ps5_q2", int'(q2), 14);
    step(0, 0, 0, 0, 0); cmp("ps6_q2", int'(q2), 14);
    step(0, 1, 0, 0, 0); cmp("ps7_q2", int'(q2), 14);
    step(0, 1, 0, 0, 0); cmp("ps8_q2", int'(q2), 13);

    // 5: reset beats load and tick in the same cycle
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 1, 3);
    cmp("rl_q0", int'(q0), 15); cmp("rl_q1", int'(q1), 11);
    cmp("rl_q2", int'(q2), 15); cmp("rl_tc0", int'(tc0), 0);
    step(0, 1, 0, 0, 0); cmp("rl1_q2", int'(q2), 15); cmp("rl1_q0", int'(q0), 14);
    step(0, 1, 0, 0, 0); cmp("rl2_q2", int'(q2), 15);
    step(0, 1, 0, 0, 0); cmp("rl3_q2", int'(q2), 14);

    // 6: stepping down from zero, then up
    step(0, 0, 0, 1, 0);
    cmp("ld0_q0", int'(q0), 0); cmp("ld0_z0", int'(z0), 1);
    for (int k = 1; k <= 3; k++) begin
      step(0, 1, 0, 0, 0);
`ifdef UDCNT_SATURATE_EN
      cmp("bnd_q0", int'(q0), 0);  cmp("bnd_tc0", int'(tc0), 1);
      cmp("bnd_z0", int'(z0), 1);
`else
      cmp("bnd_q0", int'(q0), 16 - k); cmp("bnd_tc0", int'(tc0), (k == 1) ? 1 : 0);
`endif
    end
    step(0, 1, 1, 0, 0);
`ifdef UDCNT_SATURATE_EN
    cmp("bup_q0", int'(q0), 1);
`else
    cmp("bup_q0", int'(q0), 14);
`endif
    cmp("bup_tc0", int'(tc0), 0);
    step(0, 0, 0, 0, 0);
    cmp("hold_tc0", int'(tc0), 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
